// File: rtl/hps_sdram_bridge_pkg.sv
// Purpose : shared types for the HPS-to-SDRAM host-port bridge.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package hps_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2,
        GAP      = 2'd3
    } state_t;

    // One posted write as held in the write FIFO.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fifo_entry_t;

    localparam logic [31:0] ABORT_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/hps_sdram_bridge_sync_fifo.sv
// Purpose : single-clock first-word-fall-through FIFO; dout shows the head entry.
// Latency : a pushed entry is visible on dout/empty the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports   : clk_sys/rst, push+din, pop, dout, full, empty, level (occupancy).
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset: validity is tracked by level alone.
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + (AW+1)'(1);
            else if (!do_push && do_pop) level <= level - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/hps_sdram_bridge.sv
// Purpose : turns HPS bus word accesses into sdram_controller host-port requests;
//           posted writes queue in a FIFO, reads wait for the FIFO to drain.
// Latency : accept at N -> h_req at N+2; h_ack at M -> bus_rvalid at M+1.
// Backpressure: bus_busy (FIFO full or read outstanding) drops accesses and sets err_drop.
// Ports   : clk_sys/rst; bus_* (HPS side); h_* (controller host port);
//           fifo_level, err_drop, err_timeout (status, errors sticky until rst).
module hps_sdram_bridge
    import hps_bridge_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int          TIMEOUT    = 1023,
    parameter logic [31:0] ABORT_DATA = ABORT_DATA_DEFAULT
) (
    input  logic                          clk_sys,
    input  logic                          rst,
    input  logic                          bus_cs,
    input  logic                          bus_rw,
    input  logic [31:0]                   bus_addr,
    input  logic [31:0]                   bus_wdata,
    output logic [31:0]                   bus_rdata,
    output logic                          bus_rvalid,
    output logic                          bus_busy,
    output logic [31:0]                   h_addr,
    output logic [31:0]                   h_din,
    output logic                          h_wr,
    output logic                          h_req,
    input  logic                          h_ack,
    input  logic [31:0]                   h_dout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_drop,
    output logic                          err_timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    fifo_entry_t     push_entry;
    fifo_entry_t     head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            acc_wr;
    logic            acc_rd;
    logic            pop;
    logic            in_issue;
    logic            wd_expire;
    logic            read_pending;
    logic [31:0]     rd_addr;
    logic [WD_W-1:0] wd_cnt;

    assign bus_busy   = fifo_full | read_pending;
    assign acc_wr     = bus_cs & bus_rw & ~bus_busy;
    assign acc_rd     = bus_cs & ~bus_rw & ~bus_busy;
    assign push_entry = {bus_addr, bus_wdata};
    assign in_issue   = (state == WR_ISSUE) || (state == RD_ISSUE);
    // Writes always win in IDLE, which is what makes reads coherent.
    assign pop        = (state == IDLE) && !fifo_empty;
    // An ack arriving on the expiry cycle completes the request normally.
    assign wd_expire  = in_issue && !h_ack && (wd_cnt == WD_W'(TIMEOUT - 1));

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_sys (clk_sys),
        .rst     (rst),
        .push    (acc_wr),
        .din     (push_entry),
        .pop     (pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty)       state_nxt = WR_ISSUE;
                else if (read_pending) state_nxt = RD_ISSUE;
            end
            WR_ISSUE, RD_ISSUE: begin
                if (h_ack || wd_expire) state_nxt = GAP;
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // h_req decodes straight from state so an async reset drops it at once.
    always_comb begin
        h_req = 1'b0;
        if (in_issue) h_req = 1'b1;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            h_addr       <= '0;
            h_din        <= '0;
            h_wr         <= 1'b0;
            bus_rdata    <= '0;
            bus_rvalid   <= 1'b0;
            read_pending <= 1'b0;
            rd_addr      <= '0;
            wd_cnt       <= '0;
            err_drop     <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            bus_rvalid <= 1'b0;
            // Zero outside issue states, so every new request starts from 0.
            wd_cnt     <= in_issue ? wd_cnt + WD_W'(1) : '0;

            if (acc_rd) begin
                rd_addr      <= bus_addr;
                read_pending <= 1'b1;
            end
            if (bus_cs && bus_busy) err_drop <= 1'b1;

            // Request fields load on the IDLE exit and hold until GAP.
            if (pop) begin
                h_addr <= head.addr;
                h_din  <= head.data;
                h_wr   <= 1'b1;
            end else if (state == IDLE && read_pending) begin
                h_addr <= rd_addr;
                h_wr   <= 1'b0;
            end

            if (state == RD_ISSUE && (h_ack || wd_expire)) begin
                bus_rdata    <= h_ack ? h_dout : ABORT_DATA;
                bus_rvalid   <= 1'b1;
                read_pending <= 1'b0;
            end
            if (wd_expire) err_timeout <= 1'b1;
        end
    end

endmodule
